// File: rtl/mips_pkg.sv
// Shared MIPS32 front-end definitions: BTB counter encodings, default
// exception vector and saturating-counter helpers.
package mips_pkg;

   localparam logic [1:0] CTR_SNT = 2'b00;
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

   localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'd12;

   function automatic logic [1:0] sat_inc(input logic [1:0] ctr);
      return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] ctr);
      return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
   endfunction

endpackage

// File: rtl/btb_dm.sv
// Direct-mapped BTB storage: one asynchronous lookup port and one synchronous
// resolve/update port that does its own read-modify-write of the counter.
module btb_dm
   import mips_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH),
   parameter int TAG_W = 26,
   parameter int TGT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [IDX_W-1:0] rd_idx_i,
   input  logic [TAG_W-1:0] rd_tag_i,
   output logic             rd_hit_o,
   output logic [1:0]       rd_ctr_o,
   output logic [TGT_W-1:0] rd_target_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic [TAG_W-1:0] wr_tag_i,
   input  logic             wr_taken_i,
   input  logic [TGT_W-1:0] wr_target_i
);

   logic [DEPTH-1:0] valid_q;
   logic [TAG_W-1:0] tag_q [DEPTH];
   logic [TGT_W-1:0] tgt_q [DEPTH];
   logic [1:0]       ctr_q [DEPTH];
   logic             wr_hit;

   assign rd_hit_o    = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
   assign rd_ctr_o    = ctr_q[rd_idx_i];
   assign rd_target_o = tgt_q[rd_idx_i];

   assign wr_hit = valid_q[wr_idx_i] && (tag_q[wr_idx_i] == wr_tag_i);

   // Only valid bits are reset; stale tag/target/counter data is masked by valid.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q <= '0;
      end else if (wr_en_i && wr_taken_i) begin
         valid_q[wr_idx_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         if (wr_taken_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
            tgt_q[wr_idx_i] <= wr_target_i;
            ctr_q[wr_idx_i] <= wr_hit ? sat_inc(ctr_q[wr_idx_i]) : CTR_WT;
         end else if (wr_hit) begin
            ctr_q[wr_idx_i] <= sat_dec(ctr_q[wr_idx_i]);
         end
      end
   end

endmodule

// File: rtl/next_pc_btb.sv
// Fetch PC generator with BTB prediction, decode-stage branch/jump resolution
// and the eret > exception > mispredict > stall > predict > sequential mux.
module next_pc_btb
   import mips_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter int              BTB_DEPTH  = 16,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(EXC_VECTOR_DEFAULT)
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_stall,
   input  logic            i_dec_valid,
   input  logic [XLEN-1:0] i_dec_pc,
   input  logic [XLEN-1:0] i_dec_pc_4,
   input  logic [25:0]     i_imm26,
   input  logic [XLEN-1:0] i_rs,
   input  logic            i_zero,
   input  logic            i_j,
   input  logic            i_jr,
   input  logic            i_beq,
   input  logic            i_bne,
   input  logic            i_dec_pred_taken,
   input  logic [XLEN-1:0] i_dec_pred_target,
   input  logic            i_exception,
   input  logic            i_eret,
   input  logic [XLEN-1:0] i_epc,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_pc_4,
   output logic            o_pred_taken,
   output logic [XLEN-1:0] o_pred_target,
   output logic            o_flush
);

   localparam int IDX_W = $clog2(BTB_DEPTH);
   localparam int TAG_W = XLEN - IDX_W - 2;

   logic [XLEN-1:0]  pc_q, pc_d, pc_4;
   logic             rd_hit;
   logic [1:0]       rd_ctr;
   logic [XLEN-1:0]  rd_target;
   logic [XLEN-1:0]  br_target, j_target, dec_target, fix_pc;
   logic             dec_ctl, dec_taken, mispredict, btb_wr_en;

   assign pc_4 = {pc_q[XLEN-1:2] + (XLEN-2)'(1), 2'b00};

   btb_dm #(
      .DEPTH (BTB_DEPTH),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W),
      .TGT_W (XLEN)
   ) u_btb (
      .clk_i       (i_clk),
      .rst_ni      (i_rst_n),
      .rd_idx_i    (IDX_W'(pc_q >> 2)),
      .rd_tag_i    (TAG_W'(pc_q >> (IDX_W + 2))),
      .rd_hit_o    (rd_hit),
      .rd_ctr_o    (rd_ctr),
      .rd_target_o (rd_target),
      .wr_en_i     (btb_wr_en),
      .wr_idx_i    (IDX_W'(i_dec_pc >> 2)),
      .wr_tag_i    (TAG_W'(i_dec_pc >> (IDX_W + 2))),
      .wr_taken_i  (dec_taken),
      .wr_target_i (dec_target)
   );

   assign o_pred_taken  = rd_hit & rd_ctr[1];
   assign o_pred_target = rd_hit ? rd_target : pc_4;

   assign br_target  = i_dec_pc_4 + {{(XLEN-18){i_imm26[15]}}, i_imm26[15:0], 2'b00};
   assign j_target   = {i_dec_pc_4[XLEN-1:28], i_imm26, 2'b00};
   assign dec_ctl    = i_j | i_jr | i_beq | i_bne;
   assign dec_taken  = i_j | i_jr | (i_beq & i_zero) | (i_bne & ~i_zero);
   assign dec_target = i_jr ? i_rs : (i_j ? j_target : br_target);
   assign fix_pc     = dec_taken ? dec_target : i_dec_pc_4;
   assign mispredict = i_dec_valid &
                       ((dec_taken != i_dec_pred_taken) |
                        (dec_taken & (dec_target != i_dec_pred_target)));

   // Redirects squash the BTB write so a cancelled branch never trains it.
   assign btb_wr_en = i_dec_valid & dec_ctl & ~i_eret & ~i_exception;
   assign o_flush   = i_eret | i_exception | mispredict;

   always_comb begin
      pc_d = pc_4;
      if (i_eret)                pc_d = i_epc;
      else if (i_exception)      pc_d = EXC_VECTOR;
      else if (mispredict)       pc_d = fix_pc;
      else if (i_stall)          pc_d = pc_q;
      else if (o_pred_taken)     pc_d = o_pred_target;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) pc_q <= RESET_PC;
      else          pc_q <= pc_d;
   end

   assign o_pc   = pc_q;
   assign o_pc_4 = pc_4;

endmodule
